uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal values are 1 or greater.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din  input  DATA_WIDTH  parallel byte to transmit; sampled only on the accepted start edge.
REQ-006 en  input  1  start request; sampled on the rising edge of clk.
REQ-007 ser_out  output  1  registered serial line; idle level is high.

Function
REQ-008 The block SHALL implement a state machine with exactly four states: IDLE, START, DATA, STOP; internal names state and IDLE SHALL be visible to the bench hierarchy.
REQ-009 In IDLE, when en=1 at a rising clk edge, the block SHALL latch din into a DATA_WIDTH-bit shift register and move to START on that same edge.
REQ-010 In IDLE with en=0, the block SHALL stay in IDLE with ser_out=1.
REQ-011 In START, ser_out SHALL be 0 for exactly CLKS_PER_BIT cycles, beginning on the edge that leaves IDLE; the block SHALL then go to DATA.
REQ-012 In DATA, the block SHALL send DATA_WIDTH bits, LSB first; each bit SHALL be held for CLKS_PER_BIT cycles.
REQ-013 Bit index 0 SHALL appear on the edge that leaves START; the block SHALL go to STOP after bit DATA_WIDTH-1 completes.
REQ-014 In STOP, ser_out SHALL be 1 for CLKS_PER_BIT cycles; the block SHALL then return to IDLE.
REQ-015 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles; with the defaults, 10 cycles from the en edge to state==IDLE.
REQ-016 The output SHALL be registered: ser_out changes only on rising clk edges, with zero combinational path from en or din.
REQ-017 en SHALL be ignored outside IDLE; the frame in progress continues unchanged.
REQ-018 din changes after the accepting edge SHALL NOT affect the frame in progress.
REQ-019 en held high SHALL NOT start a new frame until the block is back in IDLE. The earliest new start edge is the first edge at which the block is in IDLE, giving one idle-high cycle between stop bit and next start bit.
REQ-020 The bit-period counter SHALL be sized for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary.
REQ-021 The bit-index counter SHALL be sized for DATA_WIDTH-1 and SHALL clear on entry to DATA.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge, driving ser_out=1.

Reset
REQ-023 While reset=0, asynchronously: state=IDLE, ser_out=1, shift register=0, all counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; ser_out SHALL go high without waiting for a clock edge.
REQ-025 After reset deasserts, the block SHALL accept en on the first rising edge with reset=1.

Verification
REQ-026 Send din=0x55 with a 1-cycle en pulse (defaults) -> ser_out sequence 0,1,0,1,0,1,0,1,0,1 (start, bits 0..7, stop), one cycle each; state==IDLE 10 cycles after the en edge.
REQ-027 Send 0x00, then 0xFF -> respectively start 0, eight 0s, stop 1; and start 0, eight 1s, stop 1.
REQ-028 Back-to-back 0xAA, 0x55, 0xA5 (each issued as soon as state==IDLE) -> three correct LSB-first frames; line high between frames.
REQ-029 Pulse en and change din at cycle 3 of a frame -> en ignored, frame continues unchanged, no extra start bit afterwards.
REQ-030 Assert reset at data bit 4 -> ser_out=1 and state=IDLE immediately; after release, a new 0x5A frame transmits correctly.
REQ-031 Build with CLKS_PER_BIT=4 and send 0xC3 -> each bit held 4 cycles; 40-cycle frame; data bits 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx: UART transmitter, 8N1-style framing.
// Each frame is a low start bit, DATA_WIDTH data bits sent LSB first, and a
// high stop bit. Every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clk     : system clock; all state changes on its rising edge
//   reset   : asynchronous, active-low reset
//   din     : parallel word, captured only on the edge that accepts en
//   en      : start request, honoured only while in IDLE
//   ser_out : registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  en,
  output logic                  ser_out
);

  // Keep both counters at least one bit wide, so CLKS_PER_BIT=1 and
  // DATA_WIDTH=1 still elaborate.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  bit_done_s;

  // True on the final cycle of the current bit period.
  assign bit_done_s = (cnt_r == CNT_LAST);

  // Frame sequencer.
  // ser_out is loaded with the next bit's value on the same edge that enters
  // that bit. This keeps the line registered while starting each bit on the
  // boundary edge. The shift register always presents the next data bit at
  // shift_r[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ser_out <= 1'b1;
      shift_r <= '0;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_r <= '0;
          idx_r <= '0;
          if (en) begin
            shift_r <= din;
            ser_out <= 1'b0;
            state   <= START;
          end else begin
            ser_out <= 1'b1;
          end
        end
        START: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            ser_out <= shift_r[0];
            shift_r <= shift_r >> 1;
            state   <= DATA;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            ser_out <= 1'b0;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_r <= '0;
            if (idx_r == IDX_LAST) begin
              ser_out <= 1'b1;
              state   <= STOP;
            end else begin
              idx_r   <= idx_r + IDX_ONE;
              ser_out <= shift_r[0];
              shift_r <= shift_r >> 1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          ser_out <= 1'b1;
          if (bit_done_s) begin
            cnt_r <= '0;
            state <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          ser_out <= 1'b1;
          cnt_r   <= '0;
          idx_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx: directed self-checking bench for uart_tx.
// dut uses the default parameters. dut4 uses CLKS_PER_BIT=4.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       en;
  logic       ser_out;
  logic [7:0] din4;
  logic       en4;
  logic       ser4;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk(clk), .reset(reset), .din(din), .en(en), .ser_out(ser_out)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .din(din4), .en(en4), .ser_out(ser4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Send one frame on the default-parameter instance and check each bit.
  // After the accepting edge, din is scrambled to show it has no effect.
  // With disturb set, en is pulsed during data bit 2.
  task automatic send1(input logic [7:0] b, input bit disturb);
    @(negedge clk);
    din = b;
    en  = 1'b1;
    @(posedge clk); #1;
    chk("start_bit", {31'd0, ser_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en  = (disturb && i == 2) ? 1'b1 : 1'b0;
      din = 8'($urandom);
      @(posedge clk); #1;
      chk($sformatf("data_bit%0d_%02h", i, b), {31'd0, ser_out}, {31'd0, b[i]});
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("stop_bit", {31'd0, ser_out}, 32'd1);
    chk("not_idle_at_stop", {31'd0, dut.state == dut.IDLE}, 32'd0);
    @(posedge clk); #1;
    chk("idle_after_frame", {31'd0, dut.state == dut.IDLE}, 32'd1);
    chk("line_high_between", {31'd0, ser_out}, 32'd1);
  endtask

  logic [9:0] exp4;

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    din   = 8'h00;
    en4   = 1'b0;
    din4  = 8'h00;
    #12;
    chk("reset_line", {31'd0, ser_out}, 32'd1);
    chk("reset_state", {31'd0, dut.state == dut.IDLE}, 32'd1);
    chk("reset_line4", {31'd0, ser4}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Basic frames.
    send1(8'h55, 1'b0);
    send1(8'h00, 1'b0);
    send1(8'hFF, 1'b0);

    // Three frames back to back, each issued as soon as the block is idle.
    send1(8'hAA, 1'b0);
    send1(8'h55, 1'b0);
    send1(8'hA5, 1'b0);

    // An en pulse in mid-frame is ignored, so no extra start bit follows.
    send1(8'h3C, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_extra_start", {31'd0, ser_out}, 32'd1);
      chk("stays_idle", {31'd0, dut.state == dut.IDLE}, 32'd1);
    end

    // Reset during data bit 4 of an all-zero frame, so the line is low when
    // reset arrives.
    @(negedge clk);
    din = 8'h00;
    en  = 1'b1;
    @(posedge clk); #1;
    chk("rst_frame_start", {31'd0, ser_out}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_frame_bit4_low", {31'd0, ser_out}, 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_line", {31'd0, ser_out}, 32'd1);
    chk("async_reset_state", {31'd0, dut.state == dut.IDLE}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send1(8'h5A, 1'b0);

    // Frame with CLKS_PER_BIT=4: 40 cycles, each bit held for 4 cycles.
    exp4 = {1'b1, 8'hC3, 1'b0};
    @(negedge clk);
    din4 = 8'hC3;
    en4  = 1'b1;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        chk($sformatf("cpb4_bit%0d_cyc%0d", bi, c), {31'd0, ser4}, {31'd0, exp4[bi]});
        en4  = 1'b0;
        din4 = 8'h00;
      end
    end
    chk("cpb4_not_idle_at_39", {31'd0, dut4.state == dut4.IDLE}, 32'd0);
    @(posedge clk); #1;
    chk("cpb4_idle_at_40", {31'd0, dut4.state == dut4.IDLE}, 32'd1);
    chk("cpb4_line_high", {31'd0, ser4}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
